param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Parameters
REQ-001 DATA_WIDTH, default 8, width of data_in and data_out in bits (>=1).
REQ-002 DEPTH, default 8, number of storage entries; a power of two, >=2.
REQ-003 AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full is asserted (1..DEPTH).
REQ-004 AE_LEVEL, default 2, occupancy at or below which almost_empty is asserted (0..DEPTH-1).
REQ-005 FWFT, default 0: 0 selects standard read mode, 1 selects first-word-fall-through.

Interface (CW = $clog2(DEPTH)+1)
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 clr_err  input  1  clears the sticky error flags.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 full  output  1  occupancy == DEPTH.
REQ-014 empty  output  1  occupancy == 0.
REQ-015 almost_full  output  1  occupancy >= AF_LEVEL.
REQ-016 almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-017 count  output  CW  current occupancy.
REQ-018 overflow  output  1  sticky: a write was rejected.
REQ-019 underflow  output  1  sticky: a read was rejected.

Function
REQ-020 Write accepted iff wr_en=1 and full=0: data_in is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-021 Read accepted iff rd_en=1 and empty=0: rd_ptr increments modulo DEPTH.
REQ-022 A write while full is rejected even if a read is accepted in the same cycle; that read still completes.
REQ-023 Simultaneous accepted read and write leave count unchanged; otherwise count changes by +1 on an accepted write and -1 on an accepted read.
REQ-024 full, empty, almost_full and almost_empty are combinational decodes of the registered count; they update in the cycle after the causing edge.
REQ-025 FWFT=0: data_out is registered, loads the head entry at the edge of an accepted read, and otherwise holds its value.
REQ-026 FWFT=1: data_out presents the head entry whenever empty=0, including in the first cycle after a write into an empty FIFO; rd_en pops that entry; data_out is don't-care while empty=1.
REQ-027 Data order is strictly first-in first-out across pointer wrap-around; no entry is lost or duplicated.
REQ-028 overflow is set at the edge following wr_en=1 with full=1; underflow is set at the edge following rd_en=1 with empty=1.
REQ-029 clr_err=1 clears both sticky flags at the next edge; a new error in the same cycle takes priority and leaves its flag set.
REQ-030 Rejected operations change no pointer, count or storage entry.

Reset
REQ-031 When rst_n=0 at a rising edge: wr_ptr, rd_ptr, count, overflow, underflow and the FWFT=0 data_out register are set to 0, and wr_en, rd_en and clr_err are ignored.
REQ-032 Resulting outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0, count=0; storage contents are not reset.
REQ-033 Reset applied mid-operation discards all stored entries; the first write after reset is the first entry read back.

Verification
REQ-034 DEPTH=8, FWFT=0: write 0x11..0x18 -> full=1 and count=8; eight reads -> data_out 0x11..0x18, each one cycle after its accepted read; then empty=1.
REQ-035 Full FIFO, wr_en=1 and rd_en=1 together -> the read completes, the write is rejected, count=7, overflow=1; clr_err pulse -> overflow=0.
REQ-036 Empty FIFO, rd_en=1 -> underflow=1, count stays 0, data_out unchanged (FWFT=0).
REQ-037 FWFT=1: write 0xA5 into empty FIFO -> next cycle empty=0 and data_out=0xA5 with no rd_en; rd_en=1 -> empty=1.
REQ-038 AF_LEVEL=6, AE_LEVEL=2: fill one entry at a time -> almost_empty deasserts at count=3 and almost_full asserts at count=6.
REQ-039 Continuous write+read for 3*DEPTH cycles (wrap-around) -> output sequence matches input; then rst_n=0 for one edge with count=5 -> count=0, empty=1, flags cleared.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Read data 1 cycle after the pop (FWFT=0) or at the head (FWFT=1). Writes while full and reads while empty are dropped and flagged.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh error wins over a clear in the same cycle.
      overflow  <= (wr_en && full)  || (overflow  && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

  // Storage is not reset, but writes are still blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule
